// File: rtl/ecc_checker_scoreboard_if.sv
// Stimulus-side signals observed by the ECC checker: the APB snoop plus the DUT and golden-model results.
// The bench drives this bundle through the master modport; the checker only samples it.
interface ecc_checker_scoreboard_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
);
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [AMBA_WORD-1:0]       PRDATA;
  logic [AMBA_WORD-1:0]       regs_out;
  logic [DATA_WIDTH-1:0]      data_out;
  logic                       operation_done;
  logic [1:0]                 num_of_errors;
  logic [DATA_WIDTH-1:0]      gm_data_out;
  logic [1:0]                 gm_num_of_errors;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PRDATA, regs_out,
    output data_out, operation_done, num_of_errors, gm_data_out, gm_num_of_errors
  );

  modport slave (
    input PADDR, PSEL, PENABLE, PWRITE, PRDATA, regs_out,
    input data_out, operation_done, num_of_errors, gm_data_out, gm_num_of_errors
  );
endinterface

// File: rtl/ecc_checker_scoreboard.sv
// Watches an ECC engine against its golden model: start/done latency, result compare, APB read-back, reset values.
// All outputs are registered (visible the cycle after the detecting edge); purely observational, never stalls anything.
module ecc_checker_scoreboard #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int MAX_LATENCY     = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ecc_checker_scoreboard_if.slave bus,
  input  logic                 clr,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pass_cnt,
  output logic [CNT_WIDTH-1:0] fail_cnt,
  output logic [6:0]           err_flags,
  output logic                 err_pulse,
  output logic [2:0]           first_err,
  output logic                 first_err_vld
);

  localparam int TW = $clog2(MAX_LATENCY + 1);
  localparam logic [TW-1:0] MAX_T = TW'(MAX_LATENCY);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam int E_READ   = 0;
  localparam int E_TMO    = 1;
  localparam int E_DATA   = 2;
  localparam int E_NERR   = 3;
  localparam int E_ILLEG  = 4;
  localparam int E_RSTVAL = 5;
  localparam int E_UNEXP  = 6;

  logic [0:0]    state, nxt_state;
  logic [TW-1:0] timer, nxt_timer;
  logic          done_prev;
  logic          post_chk;

  logic          start_ev, done_ev, eval, pass_ok, any_err;
  logic [6:0]    err_det;
  logic [2:0]    first_idx;

  // Only the low address nibble selects the start register.
  logic unused_paddr;
  assign unused_paddr = ^bus.PADDR[AMBA_ADDR_WIDTH-1:4];

  assign start_ev = bus.PSEL & bus.PENABLE & bus.PWRITE & (bus.PADDR[3:0] == 4'h0);
  assign done_ev  = bus.operation_done & ~done_prev;
  assign busy     = (state == WAIT);

  always_comb begin
    err_det   = '0;
    eval      = 1'b0;
    nxt_state = state;
    nxt_timer = timer;

    err_det[E_READ] = bus.PSEL & bus.PENABLE & ~bus.PWRITE &
                      ((bus.PRDATA ^ bus.regs_out) != {AMBA_WORD{1'b0}});
    if (post_chk)
      err_det[E_RSTVAL] = (bus.data_out != {DATA_WIDTH{1'b0}}) | bus.operation_done |
                          (bus.num_of_errors != 2'd0);

    case (state)
      IDLE: begin
        if (start_ev) begin
          nxt_state = WAIT;
          nxt_timer = TW'(1);
        end else if (done_ev) begin
          err_det[E_UNEXP] = 1'b1;
        end
      end
      WAIT: begin
        if (done_ev && timer <= MAX_T) begin
          // Done is judged before a same-cycle start re-arms the window.
          eval            = 1'b1;
          err_det[E_DATA] = (bus.num_of_errors != 2'd2) && (bus.data_out != bus.gm_data_out);
          err_det[E_NERR] = (bus.num_of_errors != bus.gm_num_of_errors);
          err_det[E_ILLEG] = (bus.num_of_errors == 2'd3);
          nxt_state       = start_ev ? WAIT : IDLE;
          nxt_timer       = start_ev ? TW'(1) : '0;
        end else if (start_ev) begin
          nxt_timer = TW'(1);
        end else if (timer >= MAX_T) begin
          err_det[E_TMO] = 1'b1;
          nxt_state      = IDLE;
          nxt_timer      = '0;
        end else begin
          nxt_timer = timer + 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_timer = '0;
      end
    endcase
  end

  assign any_err = |err_det;
  assign pass_ok = eval & ~(|err_det[E_ILLEG:E_DATA]);

  always_comb begin
    first_idx = 3'd0;
    for (int i = 6; i >= 0; i--)
      if (err_det[i]) first_idx = 3'(i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      timer         <= '0;
      done_prev     <= 1'b0;
      post_chk      <= 1'b1;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      err_flags     <= '0;
      err_pulse     <= 1'b0;
      first_err     <= 3'd0;
      first_err_vld <= 1'b0;
    end else begin
      done_prev <= bus.operation_done;
      post_chk  <= 1'b0;
      if (clr) begin
        state         <= IDLE;
        timer         <= '0;
        pass_cnt      <= '0;
        fail_cnt      <= '0;
        err_flags     <= '0;
        err_pulse     <= 1'b0;
        first_err     <= 3'd0;
        first_err_vld <= 1'b0;
      end else begin
        state     <= nxt_state;
        timer     <= nxt_timer;
        err_flags <= err_flags | err_det;
        err_pulse <= any_err;
        if (any_err && !first_err_vld) begin
          first_err     <= first_idx;
          first_err_vld <= 1'b1;
        end
        if (any_err && fail_cnt != {CNT_WIDTH{1'b1}})
          fail_cnt <= fail_cnt + 1'b1;
        if (pass_ok && pass_cnt != {CNT_WIDTH{1'b1}})
          pass_cnt <= pass_cnt + 1'b1;
      end
    end
  end

endmodule
